// File: rtl/adv7611_init_pkg.sv
// adv7611_init_pkg: entry layout, sequencer states and default ADV7611 register table
package adv7611_init_pkg;
  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] saddr;
    logic [7:0] data;
  } entry_t;
  typedef enum logic [3:0] {
    S_IDLE, S_CHIP_RST, S_POST_RST, S_LOAD, S_REQ, S_WAIT, S_GAP,
    S_RETRY, S_DONE, S_FAIL, S_RD_REQ, S_RD_WAIT, S_CHECK
  } state_t;
  localparam logic [6:0] IO_MAP = 7'h4C;
  localparam logic [6:0] CP_MAP = 7'h22;
  localparam logic [6:0] HDMI_MAP = 7'h34;
  // IO map first: I2C reset, then map slave addresses, then format and HDMI setup
  function automatic entry_t default_entry(input logic [7:0] idx);
    case (idx)
      8'd0:  return {IO_MAP, 8'hFF, 8'h80};
      8'd1:  return {IO_MAP, 8'hF4, 8'h80};
      8'd2:  return {IO_MAP, 8'hF5, 8'h7C};
      8'd3:  return {IO_MAP, 8'hF8, 8'h4C};
      8'd4:  return {IO_MAP, 8'hF9, 8'h64};
      8'd5:  return {IO_MAP, 8'hFA, 8'h6C};
      8'd6:  return {IO_MAP, 8'hFB, 8'h68};
      8'd7:  return {IO_MAP, 8'hFD, 8'h44};
      8'd8:  return {IO_MAP, 8'h01, 8'h06};
      8'd9:  return {IO_MAP, 8'h02, 8'hF5};
      8'd10: return {IO_MAP, 8'h03, 8'h80};
      8'd11: return {IO_MAP, 8'h05, 8'h28};
      8'd12: return {IO_MAP, 8'h06, 8'hA6};
      8'd13: return {IO_MAP, 8'h0B, 8'h44};
      8'd14: return {IO_MAP, 8'h0C, 8'h42};
      8'd15: return {IO_MAP, 8'h14, 8'h7F};
      8'd16: return {IO_MAP, 8'h15, 8'h80};
      8'd17: return {IO_MAP, 8'h19, 8'h83};
      8'd18: return {IO_MAP, 8'h33, 8'h40};
      8'd19: return {CP_MAP, 8'hBA, 8'h01};
      8'd20: return {CP_MAP, 8'h6C, 8'h00};
      8'd21: return {HDMI_MAP, 8'h9B, 8'h03};
      8'd22: return {HDMI_MAP, 8'hC1, 8'h01};
      8'd23: return {HDMI_MAP, 8'hC2, 8'h01};
      8'd24: return {HDMI_MAP, 8'h00, 8'h08};
      8'd25: return {HDMI_MAP, 8'h02, 8'h03};
      8'd26: return {HDMI_MAP, 8'h83, 8'hFE};
      8'd27: return {HDMI_MAP, 8'h6F, 8'h0C};
      8'd28: return {HDMI_MAP, 8'h85, 8'h1F};
      8'd29: return {HDMI_MAP, 8'h87, 8'h70};
      8'd30: return {HDMI_MAP, 8'h8D, 8'h04};
      8'd31: return {HDMI_MAP, 8'h8E, 8'h1E};
      default: return '0;
    endcase
  endfunction
endpackage

// File: rtl/adv7611_init_rom.sv
// adv7611_init_rom: index-to-entry lookup; replace this file to change the per-board table
module adv7611_init_rom
  import adv7611_init_pkg::*;
(
  input  logic [7:0] idx,
  output entry_t     entry
);
  assign entry = default_entry(idx);
endmodule

// File: rtl/adv7611_init_seq.sv
// adv7611_init_seq: ADV7611 power-up sequencer driving the I2C master request/DE handshake.
// Define ADV_INIT_READBACK_EN to verify each write with a 1-byte readback.
module adv7611_init_seq
  import adv7611_init_pkg::*;
#(
  parameter int TABLE_LEN       = 32,
  parameter int RST_CYCLES      = 500_000,
  parameter int POST_RST_CYCLES = 250_000,
  parameter int GAP_CYCLES      = 64,
  parameter int MAX_RETRY       = 3,
  parameter bit AUTO_START      = 1
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       start,
  output logic       HDMI0_RX_RESET,
  output logic       i2c_wren,
  output logic [7:0] i2c_size,
  output logic       i2c_req,
  output logic [6:0] i2c_addr,
  output logic [7:0] i2c_saddr,
  output logic [7:0] i2c_tx,
  input  logic [7:0] i2c_rx,
  input  logic       i2c_de,
  input  logic       i2c_error,
  output logic       busy,
  output logic       done,
  output logic       fail,
  output logic [7:0] entry_idx,
  output logic [7:0] err_count
);
  state_t state, state_n, retry_n, ok_n;
  entry_t entry;
  logic [31:0] cnt, limit;
  logic [7:0] retry_cnt;
  logic de_q, de_rise, err_ev, cnt_hit, last;
  adv7611_init_rom rom (.idx(entry_idx), .entry(entry));
  // DE may be a level, so only its rising edge completes a transfer
  assign de_rise = i2c_de & ~de_q;
  assign limit = (state == S_CHIP_RST) ? 32'(RST_CYCLES) :
                 (state == S_POST_RST) ? 32'(POST_RST_CYCLES) : 32'(GAP_CYCLES);
  assign cnt_hit = cnt + 32'd1 >= limit;
  assign last = entry_idx == 8'(TABLE_LEN - 1);
  assign retry_n = (retry_cnt >= 8'(MAX_RETRY)) ? S_FAIL : S_RETRY;
`ifdef ADV_INIT_READBACK_EN
  logic [7:0] rd_data;
  assign ok_n = S_RD_REQ;
  assign err_ev = ((state == S_WAIT || state == S_RD_WAIT) && i2c_error) ||
                  (state == S_CHECK && rd_data != i2c_tx);
`else
  logic unused_rx;
  assign unused_rx = ^i2c_rx;
  assign ok_n = S_GAP;
  assign err_ev = state == S_WAIT && i2c_error;
`endif
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     state_n = (start || AUTO_START) ? S_CHIP_RST : S_IDLE;
      S_CHIP_RST: state_n = cnt_hit ? S_POST_RST : S_CHIP_RST;
      S_POST_RST: state_n = cnt_hit ? S_LOAD : S_POST_RST;
      S_LOAD:     state_n = S_REQ;
      S_REQ:      state_n = S_WAIT;
      S_WAIT:     state_n = err_ev ? retry_n : de_rise ? ok_n : S_WAIT;
`ifdef ADV_INIT_READBACK_EN
      S_RD_REQ:   state_n = S_RD_WAIT;
      S_RD_WAIT:  state_n = err_ev ? retry_n : de_rise ? S_CHECK : S_RD_WAIT;
      S_CHECK:    state_n = err_ev ? retry_n : S_GAP;
`endif
      S_GAP:      state_n = cnt_hit ? (last ? S_DONE : S_LOAD) : S_GAP;
      S_RETRY:    state_n = cnt_hit ? S_REQ : S_RETRY;
      S_DONE:     state_n = start ? S_CHIP_RST : S_DONE;
      S_FAIL:     state_n = start ? S_CHIP_RST : S_FAIL;
      default:    state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state <= S_IDLE;
      cnt <= '0;
      retry_cnt <= '0;
      de_q <= 1'b0;
      HDMI0_RX_RESET <= 1'b0;
      i2c_wren <= 1'b1;
      i2c_size <= 8'd1;
      i2c_req <= 1'b0;
      {i2c_addr, i2c_saddr, i2c_tx} <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      fail <= 1'b0;
      entry_idx <= '0;
      err_count <= '0;
`ifdef ADV_INIT_READBACK_EN
      rd_data <= '0;
`endif
    end else begin
      state <= state_n;
      cnt <= (state_n != state) ? '0 : cnt + 32'd1;
      de_q <= i2c_de;
      HDMI0_RX_RESET <= (state_n == S_CHIP_RST) ? 1'b0 : (state == S_CHIP_RST) ? 1'b1 : HDMI0_RX_RESET;
      i2c_size <= 8'd1;
      i2c_req <= state_n == S_WAIT || state_n == S_RD_WAIT;
      busy <= !(state_n inside {S_IDLE, S_DONE, S_FAIL});
      done <= state_n == S_DONE;
      fail <= state_n == S_FAIL;
      if (state == S_LOAD) {i2c_addr, i2c_saddr, i2c_tx} <= entry;
`ifdef ADV_INIT_READBACK_EN
      i2c_wren <= !(state_n inside {S_RD_REQ, S_RD_WAIT, S_CHECK});
      if (state == S_RD_WAIT && de_rise) rd_data <= i2c_rx;
`else
      i2c_wren <= 1'b1;
`endif
      if (state_n == S_CHIP_RST && state != S_CHIP_RST) begin
        entry_idx <= '0;
        err_count <= '0;
        retry_cnt <= '0;
      end else begin
        if (state == S_GAP && state_n == S_LOAD) begin
          entry_idx <= entry_idx + 8'd1;
          retry_cnt <= '0;
        end
        if (state == S_RETRY && state_n == S_REQ) retry_cnt <= retry_cnt + 8'd1;
        if (err_ev && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_adv7611_init_seq.sv
// tb_adv7611_init_seq: scoreboard bench with a small I2C master model for the init sequencer
module tb_adv7611_init_seq;
  localparam int M_OK = 0, M_ERR1 = 1, M_ERR2 = 2, M_LEVEL = 3, M_BOTH = 4, M_HANG = 5;
  localparam logic [22:0] E0 = {7'h4C, 8'hFF, 8'h80};
  localparam logic [22:0] E1 = {7'h4C, 8'hF4, 8'h80};
  localparam logic [22:0] E2 = {7'h4C, 8'hF5, 8'h7C};
  typedef struct packed {
    logic       done;
    logic       fail;
    logic [7:0] idx;
    logic [7:0] err;
    logic [7:0] srv;
  } status_t;
  logic CLOCK_50 = 1'b0, RESET = 1'b1, start = 1'b0;
  logic HDMI0_RX_RESET, i2c_wren, i2c_req, busy, done, fail;
  logic [7:0] i2c_size, i2c_saddr, i2c_tx, entry_idx, err_count;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_rx = 8'h00;
  logic i2c_de = 1'b0, i2c_error = 1'b0;
  int total = 0, bad = 0;
  int mode = M_OK;
  int served = 0;
  int att [4];
  logic [22:0] req_q [$];
  status_t st_q [$];

  adv7611_init_seq #(
    .TABLE_LEN(3), .RST_CYCLES(8), .POST_RST_CYCLES(4),
    .GAP_CYCLES(4), .MAX_RETRY(3), .AUTO_START(1'b1)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .start(start),
    .HDMI0_RX_RESET(HDMI0_RX_RESET), .i2c_wren(i2c_wren), .i2c_size(i2c_size),
    .i2c_req(i2c_req), .i2c_addr(i2c_addr), .i2c_saddr(i2c_saddr), .i2c_tx(i2c_tx),
    .i2c_rx(i2c_rx), .i2c_de(i2c_de), .i2c_error(i2c_error),
    .busy(busy), .done(done), .fail(fail), .entry_idx(entry_idx), .err_count(err_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic status_t mk(input logic d, input logic f, input int i, input int e, input int s);
    return {d, f, 8'(i), 8'(e), 8'(s)};
  endfunction

  // I2C master model: ACK with a 1-cycle DE about 20 cycles after a request
  initial begin : i2c_model
    int idx, hold;
    bit er;
    forever begin
      @(negedge CLOCK_50);
      if (i2c_req === 1'b1) begin
        idx = int'(entry_idx) & 3;
        att[idx]++;
        if (mode == M_HANG && idx == 1 && att[idx] == 1) begin
          for (int k = 0; k < 5000 && i2c_req === 1'b1; k++) @(negedge CLOCK_50);
        end else begin
          repeat (19) @(negedge CLOCK_50);
          er = ((mode == M_ERR1 || mode == M_BOTH) && idx == 1 && att[idx] == 1) ||
               (mode == M_ERR2 && idx == 2);
          hold = (mode == M_LEVEL && idx == 0) ? 50 : 1;
          i2c_error = er;
          i2c_de = !er || mode == M_BOTH;
          served++;
          repeat (hold) @(negedge CLOCK_50);
          i2c_de = 1'b0;
          i2c_error = 1'b0;
        end
      end
    end
  end

  initial begin : req_mon
    logic prev;
    logic [22:0] r;
    prev = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if (i2c_req === 1'b1 && !prev) begin
        if (req_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_req actual=%h required=none", {i2c_addr, i2c_saddr, i2c_tx});
        end else begin
          r = req_q.pop_front();
          chk("req_entry", 32'({i2c_addr, i2c_saddr, i2c_tx}), 32'(r));
          chk("req_wren", 32'(i2c_wren), 32'd1);
          chk("req_size", 32'(i2c_size), 32'd1);
        end
      end
      prev = i2c_req === 1'b1;
    end
  end

  initial begin : st_mon
    logic prev;
    status_t s;
    prev = 1'b0;
    forever begin
      @(negedge CLOCK_50);
      if ((done === 1'b1 || fail === 1'b1) && !prev) begin
        if (st_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_end actual=done%b/fail%b required=none", done, fail);
        end else begin
          s = st_q.pop_front();
          chk("done", 32'(done), 32'(s.done));
          chk("fail", 32'(fail), 32'(s.fail));
          chk("end_busy", 32'(busy), 32'd0);
          chk("entry_idx", 32'(entry_idx), 32'(s.idx));
          chk("err_count", 32'(err_count), 32'(s.err));
          chk("model_responses", 32'(served), 32'(s.srv));
        end
      end
      prev = done === 1'b1 || fail === 1'b1;
    end
  end

  task automatic setup(input int m);
    mode = m;
    served = 0;
    foreach (att[i]) att[i] = 0;
  endtask

  task automatic do_reset(input string name);
    int n;
    RESET = 1'b1;
    @(negedge CLOCK_50);
    chk({name, "_rx_reset"}, 32'(HDMI0_RX_RESET), 32'd0);
    chk({name, "_req"}, 32'(i2c_req), 32'd0);
    chk({name, "_wren_size"}, 32'({i2c_wren, i2c_size}), 32'h101);
    chk({name, "_entry_regs"}, 32'({i2c_addr, i2c_saddr, i2c_tx}), 32'd0);
    chk({name, "_flags"}, 32'({busy, done, fail}), 32'd0);
    chk({name, "_idx_err"}, 32'({entry_idx, err_count}), 32'd0);
    repeat (2) @(negedge CLOCK_50);
    RESET = 1'b0;
    n = 0;
    while (HDMI0_RX_RESET !== 1'b1 && n < 100) begin
      n++;
      @(negedge CLOCK_50);
    end
    chk({name, "_rx_low_cycles"}, 32'(n), 32'd9);
  endtask

  task automatic pulse_start();
    @(negedge CLOCK_50);
    start = 1'b1;
    @(negedge CLOCK_50);
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && fail !== 1'b1 && n < 3000) begin
      n++;
      @(negedge CLOCK_50);
    end
    if (done !== 1'b1 && fail !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s_timeout actual=busy required=done_or_fail", name);
    end
    repeat (60) @(negedge CLOCK_50);
    chk({name, "_reqs_left"}, 32'(req_q.size()), 32'd0);
    chk({name, "_ends_left"}, 32'(st_q.size()), 32'd0);
  endtask

  initial begin
    int m;
    setup(M_OK);
    req_q = '{E0, E1, E2};
    st_q.push_back(mk(1, 0, 2, 0, 3));
    do_reset("por");
    m = 0;
    while (i2c_req !== 1'b1 && m < 100) begin
      m++;
      @(negedge CLOCK_50);
    end
    chk("first_req_latency", 32'(m), 32'd6);
    wait_end("basic");

    setup(M_ERR1);
    req_q = '{E0, E1, E1, E2};
    st_q.push_back(mk(1, 0, 2, 1, 4));
    pulse_start();
    wait_end("retry_once");

    setup(M_ERR2);
    req_q = '{E0, E1, E2, E2, E2, E2};
    st_q.push_back(mk(0, 1, 2, 4, 6));
    pulse_start();
    wait_end("retry_exhaust");

    setup(M_LEVEL);
    req_q = '{E0, E1, E2};
    st_q.push_back(mk(1, 0, 2, 0, 3));
    pulse_start();
    wait_end("level_de");

    setup(M_BOTH);
    req_q = '{E0, E1, E1, E2};
    st_q.push_back(mk(1, 0, 2, 1, 4));
    pulse_start();
    wait_end("de_and_error");

    setup(M_HANG);
    req_q = '{E0, E1, E0, E1, E2};
    st_q.push_back(mk(1, 0, 2, 0, 4));
    pulse_start();
    m = 0;
    while (!(i2c_req === 1'b1 && entry_idx == 8'd1) && m < 2000) begin
      m++;
      @(negedge CLOCK_50);
    end
    if (m >= 2000) begin
      total++;
      bad++;
      $display("FAIL mid_wait_entry1 actual=no_req required=req_entry1");
    end
    do_reset("mid_rst");
    wait_end("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
